seq_alu: RTL and testbench

//  Parametrised, registered successor to the 8-bit combinational myALU: WIDTH-bit operands,
//  4-bit opcode, status flags, valid/ready handshake on both sides, and an iterative multiply.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/seq_alu_if.sv | 23 ++
 rtl/mul_iter.sv | 53 +++++
 rtl/seq_alu.sv | 141 ++++++++++++++
 tb/tb_seq_alu.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int F_ZERO  = 0;
  localparam int F_CARRY = 1;
  localparam int F_OVF   = 2;
  localparam int F_NEG   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between an operand source, the ALU and a result consumer.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opc;
  logic [WIDTH-1:0] v1;
  logic [WIDTH-1:0] v2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;
  logic             err;

  modport master (
    output in_valid, opc, v1, v2, out_ready,
    input  in_ready, out_valid, out, flags, err
  );

  modport slave (
    input  in_valid, opc, v1, v2, out_ready,
    output in_ready, out_valid, out, flags, err
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_p0;
  logic [2*WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [2*WIDTH-1:0] acc_next;

  // Final iteration's add is folded in combinationally so the result is ready on the last edge.
  assign acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign prod     = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc_p0    <= '0;
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
    end else if (busy) begin
      acc_p0    <= acc_next;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake, status flags, one-entry result buffer and iterative MUL.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             err;
  } result_t;

  function automatic result_t alu_eval(logic [3:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    result_t                 r;
    logic [WIDTH:0]          wide;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    r    = '0;
    wide = '0;
    sa   = a;
    sb   = b;
    case (op)
      OP_ADD: begin
        wide             = {1'b0, a} + {1'b0, b};
        r.res            = wide[WIDTH-1:0];
        r.flags[F_CARRY] = wide[WIDTH];
        r.flags[F_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (r.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide             = {1'b0, a} - {1'b0, b};
        r.res            = wide[WIDTH-1:0];
        r.flags[F_CARRY] = wide[WIDTH];
        r.flags[F_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (r.res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: r.res = a << b[SHW-1:0];
      OP_SHR: r.res = a >> b[SHW-1:0];
      OP_SLT: r.res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_MUL: r.res = '0;
      default: r.err = 1'b1;
    endcase
    // Illegal opcodes report all-zero flags, so zero/neg are only derived for legal ones.
    if (!r.err) begin
      r.flags[F_ZERO] = (r.res == '0);
      r.flags[F_NEG]  = r.res[WIDTH-1];
    end
    return r;
  endfunction

  function automatic result_t mul_eval(logic [2*WIDTH-1:0] p);
    result_t r;
    r                = '0;
    r.res            = p[WIDTH-1:0];
    r.flags[F_CARRY] = |p[2*WIDTH-1:WIDTH];
    r.flags[F_OVF]   = |p[2*WIDTH-1:WIDTH];
    r.flags[F_ZERO]  = (r.res == '0);
    r.flags[F_NEG]   = r.res[WIDTH-1];
    return r;
  endfunction

  state_t             state;
  state_t             state_next;
  logic               in_ready;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  result_t            alu_res;
  result_t            mul_res;
  result_t            res_p1;
  logic               vld_p1;

  assign in_ready     = (state == ST_IDLE) && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && in_ready;
  assign alu_res      = alu_eval(bus.opc, bus.v1, bus.v2);
  assign mul_res      = mul_eval(mul_prod);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out       = res_p1.res;
  assign bus.flags     = res_p1.flags;
  assign bus.err       = res_p1.err;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.v1),
    .b     (bus.v2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && (bus.opc == OP_MUL)) begin
          mul_start  = 1'b1;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result buffer stage: loaded by a single-cycle accept or MUL completion, drained by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (accept && (bus.opc != OP_MUL)) begin
      vld_p1 <= 1'b1;
      res_p1 <= alu_res;
    end else if (mul_done) begin
      vld_p1 <= 1'b1;
      res_p1 <= mul_res;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=8: ops, flags, handshake, MUL latency and reset abort.
module tb_seq_alu;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_alu_if #(.WIDTH(8)) bus();

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] v1;
    logic [7:0] v2;
    logic [7:0] exp;
    logic [3:0] fl;   // {neg, ovf, carry, zero}
    logic       err;
  } vec_t;

  vec_t vecs [0:13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = valid;
    bus.opc      = op;
    bus.v1       = a;
    bus.v2       = b;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.flags, bus.err} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b out=%h flags=%b err=%b, want all zero",
               bus.out_valid, bus.out, bus.flags, bus.err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ops();
    vecs[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'b0011, 1'b0};
    vecs[1]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 4'b0100, 1'b0};
    vecs[2]  = '{4'h7, 8'h80, 8'h01, 8'h01, 4'b0000, 1'b0};
    vecs[3]  = '{4'h7, 8'h01, 8'h80, 8'h00, 4'b0001, 1'b0};
    vecs[4]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
    vecs[5]  = '{4'h3, 8'h0F, 8'hF0, 8'hFF, 4'b1000, 1'b0};
    vecs[6]  = '{4'h4, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1'b0};
    vecs[7]  = '{4'h5, 8'h81, 8'h09, 8'h02, 4'b0000, 1'b0};
    vecs[8]  = '{4'h5, 8'h01, 8'h08, 8'h01, 4'b0000, 1'b0};
    vecs[9]  = '{4'h6, 8'h80, 8'h07, 8'h01, 4'b0000, 1'b0};
    vecs[10] = '{4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010, 1'b0};
    vecs[11] = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100, 1'b0};
    vecs[12] = '{4'hC, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1};
    vecs[13] = '{4'h2, 8'hFF, 8'h0F, 8'h0F, 4'b0000, 1'b0};
    bus.out_ready = 1'b1;
    // Streamed back to back: one accept and one result per cycle.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].opc, vecs[i].v1, vecs[i].v2);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_in_ready: got %b want 1", i, bus.in_ready);
      end
      step();
      checks++;
      if ({bus.out_valid, bus.out, bus.flags, bus.err} !== {1'b1, vecs[i].exp, vecs[i].fl, vecs[i].err}) begin
        failures++;
        $display("FAIL op%0d_opc%h: got valid=%b out=%h flags=%b err=%b, want valid=1 out=%h flags=%b err=%b",
                 i, vecs[i].opc, bus.out_valid, bus.out, bus.flags, bus.err,
                 vecs[i].exp, vecs[i].fl, vecs[i].err);
      end
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ops_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                         input logic [3:0] fl, input string name);
    int n;
    bit ready_seen;
    drive(1'b1, 4'h8, a, b);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept_ready: got %b want 1", name, bus.in_ready);
    end
    step();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    n = 0;
    ready_seen = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles want 8", name, n);
    end
    checks++;
    if (ready_seen) begin
      failures++;
      $display("FAIL %s_busy_ready: in_ready rose during MUL, want 0 throughout", name);
    end
    checks++;
    if ({bus.out, bus.flags, bus.err} !== {exp, fl, 1'b0}) begin
      failures++;
      $display("FAIL %s_result: got out=%h flags=%b err=%b want out=%h flags=%b err=0",
               name, bus.out, bus.flags, bus.err, exp, fl);
    end
  endtask

  task automatic test_mul();
    bus.out_ready = 1'b1;
    run_mul(8'h0D, 8'h0B, 8'h8F, 4'b1000, "mul_0d_0b");
    run_mul(8'h10, 8'h10, 8'h00, 4'b0111, "mul_10_10");
    step();
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h0, 8'h03, 8'h04);
    step();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    step();
    checks++;
    if ({bus.out_valid, bus.out, bus.flags, bus.in_ready} !== {1'b1, 8'h07, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL bp_hold: got valid=%b out=%h flags=%b in_ready=%b want valid=1 out=07 flags=0000 in_ready=0",
               bus.out_valid, bus.out, bus.flags, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h4, 8'hF0, 8'hFF);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
    end
    step();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.out, bus.flags} !== {1'b1, 8'h0F, 4'b0000}) begin
      failures++;
      $display("FAIL bp_swap: got valid=%b out=%h flags=%b want valid=1 out=0f flags=0000",
               bus.out_valid, bus.out, bus.flags);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    bit stale;
    bus.out_ready = 1'b1;
    drive(1'b1, 4'h8, 8'h0D, 8'h0B);
    step();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid);
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready);
    end
    stale = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("FAIL rst_mid_stale: out_valid rose after reset abort, want 0");
    end
    drive(1'b1, 4'h0, 8'h03, 8'h04);
    step();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    checks++;
    if ({bus.out_valid, bus.out} !== {1'b1, 8'h07}) begin
      failures++;
      $display("FAIL rst_mid_recover: got valid=%b out=%h want valid=1 out=07", bus.out_valid, bus.out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ops();
    test_mul();
    test_back_pressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
